axis_decimator: RTL and testbench
=================================

// Module: axis_decimator
// PURPOSE
// - Parametrised successor to the single-lane AXIS throttle: reduces an AXI4-Stream sample rate by 2^log_decim.
// - Two modes: DROP (forward one sample per group) and AVG (boxcar mean of the group).
// - CHANNELS lanes are packed in tdata and processed in parallel.
// - Sits between the ADC/filter chain and the DMA/FIFO writer; has a registered output stage with full backpressure.
// PARAMETERS
// - AXIS_TDATA_WIDTH  16  width of one channel sample, two's complement
// - CHANNELS           2  lanes packed in tdata, lane k = tdata[k*W +: W]
// - MAX_LOG_DECIM     16  largest supported log2 ratio; sets accumulator width W+MAX_LOG_DECIM
// - LOG_WIDTH          5  width of log_decim; must satisfy 2^LOG_WIDTH > MAX_LOG_DECIM
// PORTS
// - aclk           in   1                   single clock, all logic rising-edge
// - areset         in   1                   synchronous reset, active-high
// - mode_avg       in   1                   0 = DROP, 1 = AVG
// - log_decim      in   LOG_WIDTH           log2 decimation ratio; values > MAX_LOG_DECIM clamp to MAX_LOG_DECIM
// - S_AXIS_tready  out  1                   input ready
// - S_AXIS_tvalid  in   1                   input valid
// - S_AXIS_tdata   in   CHANNELS*W          input samples
// - M_AXIS_tready  in   1                   output ready
// - M_AXIS_tvalid  out  1                   output valid (registered)
// - M_AXIS_tdata   out  CHANNELS*W          output samples (registered)
// - group_restart  out  1                   one-cycle pulse when a config change aborts a partial group
// BEHAVIOUR
// - Reset: M_AXIS_tvalid=0, M_AXIS_tdata=0, group_restart=0, count=0, accumulators=0, cfg shadow = current inputs (clamped).
//   S_AXIS_tready is combinational and is 1 during the cycle after reset.
// - S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready (no combinational path from S_AXIS_tvalid).
// - A beat is accepted when S_AXIS_tvalid & S_AXIS_tready; only accepted beats advance count.
// - Config shadow: N = 2^L, L = shadowed log_decim. The shadow (mode, L) reloads whenever count==0.
//   Inputs changing mid-group do not affect that group, except as follows:
//   - If count!=0 and (mode_avg, clamped log_decim) != shadow for 2 consecutive cycles, the partial group is discarded:
//     count=0, accumulators=0, shadow reloads, group_restart pulses.
//   - Any beat accepted in that same cycle is dropped.
// - count runs 0..N-1. On the accepted beat with count==N-1:
//   - count wraps to 0.
//   - The output register loads at that edge, so latency is 1 cycle from the last beat's acceptance edge to M_AXIS_tvalid=1.
// - DROP: each lane outputs the sample of beat N-1 of the group.
// - AVG, per lane:
//   - acc = sign-extended sum of the N samples, width W+MAX_LOG_DECIM.
//   - Output = acc >>> L (arithmetic shift, floor rounding), truncated to W bits. This cannot overflow.
//   - Beat 0 of a group loads acc with the sample instead of adding.
// - L=0: every accepted beat is forwarded unchanged in both modes; latency stays 1 cycle.
// - Output hold: while M_AXIS_tvalid & ~M_AXIS_tready, M_AXIS_tdata is stable and no beat is accepted (tready=0).
//   A new result may load in the same cycle the old one is consumed, so 1 beat/cycle throughput is sustained at L=0.
// - M_AXIS_tvalid clears on a handshake unless a new result loads in the same edge.
// - Reset mid-group or mid-hold: the pending output and the partial group are discarded with no residue.
// STRUCTURE
// - Package axis_decimator_pkg:
//   - typedef enum logic {MODE_DROP, MODE_AVG} decim_mode_t;
//   - function clamp_log(); accumulator-width localparam.
// - Sub-module axis_decimator_lane: one lane's accumulator and result mux.
//   - Inputs: first, last, mode, L, sample.
//   - Output: result.
//   - Instantiated CHANNELS times by a generate loop.
// - Top: count, cfg shadow, restart detector, output register and handshake.
// TESTING
// 1. L=0, DROP, tvalid=1 and tready=1 for 8 beats -> 8 outputs, identical data, 1-cycle latency, no bubbles.
// 2. L=2, AVG, CHANNELS=2:
//    - lane0 = 1,2,3,4 -> 2 (10>>>2)
//    - lane1 = -1,-2,-3,-4 -> -3 (floor of -2.5)
//    - exactly one output per 4 accepted beats.
// 3. L=3, DROP, input 0..15 -> outputs 7 and 15; M_AXIS_tready held 0 for 5 cycles after the first output ->
//    S_AXIS_tready=0, M_AXIS_tdata stays 7, no input lost.
// 4. AVG, W=16, L=16, 65536 beats of 0x7FFF -> output 0x7FFF; 65536 beats of 0x8000 -> 0x8000 (no overflow).
// 5. L=2, after 2 beats change log_decim to 1 and hold it ->
//    - group_restart pulses once
//    - the next outputs use N=2
//    - a change held 1 cycle then reverted causes no restart.
// 6. Assert areset mid-group with an output stalled -> tvalid=0 on the next cycle; the next group starts at count 0;
//    the stalled value never appears.

Source files
------------

// File: rtl/axis_decimator_pkg.sv
// Shared types and helpers for the AXI4-Stream decimator.
// Lanes and top import this so mode encoding and widths stay in one place.
package axis_decimator_pkg;

  typedef enum logic {
    MODE_DROP = 1'b0,
    MODE_AVG  = 1'b1
  } decim_mode_t;

  localparam int DEFAULT_SAMPLE_WIDTH  = 16;
  localparam int DEFAULT_MAX_LOG_DECIM = 16;

  // Headroom of MAX_LOG_DECIM bits lets a full group of extreme samples sum without wrapping.
  function automatic int acc_width(int sampleWidth, int maxLog);
    return sampleWidth + maxLog;
  endfunction

  function automatic int clamp_log(int logDecim, int maxLog);
    return (logDecim > maxLog) ? maxLog : logDecim;
  endfunction

endpackage

// File: rtl/axis_decimator_if.sv
// AXI4-Stream beat bundle (valid/ready/data) with producer and consumer views.
interface axis_decimator_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_decimator_lane.sv
// One channel of the decimator: boxcar accumulator plus DROP/AVG result select.
// The result is combinational; the top registers it on the last beat of a group.
module axis_decimator_lane
  import axis_decimator_pkg::*;
#(
  parameter int W             = DEFAULT_SAMPLE_WIDTH,
  parameter int MAX_LOG_DECIM = DEFAULT_MAX_LOG_DECIM,
  parameter int LOG_WIDTH     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic                 first_i,
  input  logic                 last_i,
  input  decim_mode_t          mode_i,
  input  logic [LOG_WIDTH-1:0] log_i,
  input  logic [W-1:0]         sample_i,
  output logic [W-1:0]         result_o
);
  localparam int A = acc_width(W, MAX_LOG_DECIM);

  logic signed [A-1:0] acc_q, acc_d;
  logic signed [A-1:0] sampleExt, sum, shifted;

  assign sampleExt = {{MAX_LOG_DECIM{sample_i[W-1]}}, sample_i};
  assign sum       = first_i ? sampleExt : acc_q + sampleExt;
  assign shifted   = sum >>> log_i;
  assign result_o  = (mode_i == MODE_AVG) ? shifted[W-1:0] : sample_i;

  // Accumulator empties after the closing beat so an aborted or finished group leaves nothing behind.
  always_comb begin
    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = last_i ? '0 : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/axis_decimator.sv
// AXI4-Stream decimator by 2^log_decim with DROP or boxcar AVG per lane.
// Holds group count, config shadow, restart detector and the registered output stage.
module axis_decimator
  import axis_decimator_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int CHANNELS         = 2,
  parameter int MAX_LOG_DECIM    = DEFAULT_MAX_LOG_DECIM,
  parameter int LOG_WIDTH        = 5
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 mode_avg,
  input  logic [LOG_WIDTH-1:0] log_decim,
  axis_decimator_if.slave      S_AXIS,
  axis_decimator_if.master     M_AXIS,
  output logic                 group_restart
);
  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int CW = MAX_LOG_DECIM;
  localparam logic [CW:0] SPAN_ONE = 1;

  decim_mode_t          reqMode, shadowMode_q, effMode;
  logic [LOG_WIDTH-1:0] clampedLog, shadowLog_q, effLog;
  logic [CW-1:0]        count_q, count_d, lastIdx;
  logic [CW:0]          groupSpan;
  logic                 groupIdle, cfgDiff, restart;
  logic                 pending_q, pending_d, restart_q;
  logic                 sReady, accept, lastBeat, loadOut;
  logic                 outValid_q, outValid_d;
  logic [CHANNELS*W-1:0] outData_q, outData_d, laneResult;

  assign clampedLog = LOG_WIDTH'(clamp_log(int'(log_decim), MAX_LOG_DECIM));
  assign reqMode    = mode_avg ? MODE_AVG : MODE_DROP;

  // Beat 0 of a group sees the live config; later beats use the copy taken at group start.
  assign groupIdle = (count_q == '0);
  assign effMode   = groupIdle ? reqMode : shadowMode_q;
  assign effLog    = groupIdle ? clampedLog : shadowLog_q;
  assign groupSpan = SPAN_ONE << effLog;
  assign lastIdx   = CW'(groupSpan - 1'b1);
  assign lastBeat  = (count_q == lastIdx);

  // A mismatch must persist for two cycles mid-group before the partial group is thrown away.
  assign cfgDiff   = (reqMode != shadowMode_q) || (clampedLog != shadowLog_q);
  assign restart   = !groupIdle && cfgDiff && pending_q;
  assign pending_d = !groupIdle && cfgDiff && !restart;

  assign sReady  = ~outValid_q | M_AXIS.tready;
  assign accept  = S_AXIS.tvalid & sReady & ~restart;
  assign loadOut = accept & lastBeat;

  always_comb begin
    count_d = count_q;
    if (restart)     count_d = '0;
    else if (accept) count_d = lastBeat ? '0 : count_q + 1'b1;
  end

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (loadOut) begin
      outValid_d = 1'b1;
      outData_d  = laneResult;
    end else if (M_AXIS.tready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      count_q      <= '0;
      shadowMode_q <= reqMode;
      shadowLog_q  <= clampedLog;
      pending_q    <= 1'b0;
      restart_q    <= 1'b0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
    end else begin
      count_q    <= count_d;
      pending_q  <= pending_d;
      restart_q  <= restart;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      if (groupIdle || restart) begin
        shadowMode_q <= reqMode;
        shadowLog_q  <= clampedLog;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : gLane
    axis_decimator_lane #(
      .W             (W),
      .MAX_LOG_DECIM (MAX_LOG_DECIM),
      .LOG_WIDTH     (LOG_WIDTH)
    ) uLane (
      .clk      (aclk),
      .rst      (areset),
      .en_i     (accept),
      .clear_i  (restart),
      .first_i  (groupIdle),
      .last_i   (lastBeat),
      .mode_i   (effMode),
      .log_i    (effLog),
      .sample_i (S_AXIS.tdata[k*W +: W]),
      .result_o (laneResult[k*W +: W])
    );
  end

  assign S_AXIS.tready = sReady;
  assign M_AXIS.tvalid = outValid_q;
  assign M_AXIS.tdata  = outData_q;
  assign group_restart = restart_q;

endmodule

// File: tb/tb_axis_decimator.sv
// Directed self-checking bench for axis_decimator (W=16, 2 lanes, MAX_LOG_DECIM=16).
// Inputs change #1 after posedge; handshakes are observed on the falling edge.
module tb_axis_decimator;
  localparam int W    = 16;
  localparam int CH   = 2;
  localparam int MAXL = 16;
  localparam int LW   = 5;
  localparam int DW   = W * CH;

  logic          aclk = 1'b0;
  logic          areset;
  logic          mode_avg;
  logic [LW-1:0] log_decim;
  logic          group_restart;

  axis_decimator_if #(.DATA_WIDTH(DW)) sIf ();
  axis_decimator_if #(.DATA_WIDTH(DW)) mIf ();

  axis_decimator #(
    .AXIS_TDATA_WIDTH (W),
    .CHANNELS         (CH),
    .MAX_LOG_DECIM    (MAXL),
    .LOG_WIDTH        (LW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .mode_avg      (mode_avg),
    .log_decim     (log_decim),
    .S_AXIS        (sIf),
    .M_AXIS        (mIf),
    .group_restart (group_restart)
  );

  always #5 aclk = ~aclk;

  int assertCount  = 0;
  int failCount    = 0;
  int restartCount = 0;
  int cycleNo      = 0;
  logic [DW-1:0] outQ[$];
  int outCycQ[$];
  int inCycQ[$];

  logic [DW-1:0] t2In [8] = '{32'hFFFF_0001, 32'hFFFE_0002, 32'hFFFD_0003, 32'hFFFC_0004,
                              32'h0007_0064, 32'h0000_0064, 32'h0000_0064, 32'h0000_0065};

  always @(posedge aclk) cycleNo <= cycleNo + 1;

  always @(negedge aclk) begin
    if (!areset && mIf.tvalid && mIf.tready) begin
      outQ.push_back(mIf.tdata);
      outCycQ.push_back(cycleNo);
    end
    if (!areset && sIf.tvalid && sIf.tready) inCycQ.push_back(cycleNo);
    if (group_restart) restartCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data);
    bit accepted = 1'b0;
    sIf.tvalid = 1'b1;
    sIf.tdata  = data;
    for (int t = 0; t < 64 && !accepted; t++) begin
      @(negedge aclk);
      accepted = sIf.tready;
      @(posedge aclk);
      #1;
    end
    sIf.tvalid = 1'b0;
    if (!accepted) checkOutput("beatTimeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW-1:0] qData(input int i);
    return (i < outQ.size()) ? outQ[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int qOutCyc(input int i);
    return (i < outCycQ.size()) ? outCycQ[i] : -1000;
  endfunction

  function automatic int qInCyc(input int i);
    return (i < inCycQ.size()) ? inCycQ[i] : -2000;
  endfunction

  task automatic clearQueues();
    outQ.delete();
    outCycQ.delete();
    inCycQ.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int baseRestart;
    bit seen;
    logic [DW-1:0] t1Exp [8];

    sIf.tvalid  = 1'b0;
    sIf.tdata   = '0;
    mIf.tready  = 1'b1;
    mode_avg    = 1'b0;
    log_decim   = '0;
    areset      = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    @(negedge aclk);
    checkOutput("rstValid",   32'(mIf.tvalid), 32'd0);
    checkOutput("rstData",    mIf.tdata, 32'd0);
    checkOutput("rstRestart", 32'(group_restart), 32'd0);
    checkOutput("rstReady",   32'(sIf.tready), 32'd1);
    idle(1);

    // L=0 pass-through: every beat forwarded one cycle later, back to back.
    $display("[TB] test 1: L=0 DROP streaming");
    clearQueues();
    for (int i = 0; i < 8; i++) begin
      t1Exp[i] = {16'h0A00 + 16'(i), 16'h0010 + 16'(i * 3)};
      applyStimulus(t1Exp[i]);
    end
    idle(3);
    checkOutput("t1Count", 32'(outQ.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t1Data%0d", i), qData(i), t1Exp[i]);
      checkOutput($sformatf("t1Latency%0d", i), 32'(qOutCyc(i) - qInCyc(i)), 32'd1);
      checkOutput($sformatf("t1Gap%0d", i), 32'(qInCyc(i) - qInCyc(0)), 32'(i));
    end

    $display("[TB] test 2: L=2 AVG");
    clearQueues();
    mode_avg  = 1'b1;
    log_decim = 5'd2;
    for (int i = 0; i < 4; i++) applyStimulus(t2In[i]);
    idle(2);
    checkOutput("t2CountA", 32'(outQ.size()), 32'd1);
    checkOutput("t2Avg0", qData(0), 32'hFFFD_0002);
    for (int i = 4; i < 7; i++) applyStimulus(t2In[i]);
    idle(2);
    checkOutput("t2CountB", 32'(outQ.size()), 32'd1);
    applyStimulus(t2In[7]);
    idle(2);
    checkOutput("t2CountC", 32'(outQ.size()), 32'd2);
    checkOutput("t2Avg1", qData(1), 32'h0001_0064);

    $display("[TB] test 3: L=3 DROP with output stall");
    clearQueues();
    mode_avg   = 1'b0;
    log_decim  = 5'd3;
    mIf.tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) applyStimulus({16'h0100 + 16'(i), 16'(i)});
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge aclk);
          seen = mIf.tvalid;
        end
        checkOutput("t3FirstValid", 32'(seen), 32'd1);
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge aclk);
          checkOutput($sformatf("t3HoldReady%0d", c), 32'(sIf.tready), 32'd0);
          checkOutput($sformatf("t3HoldData%0d", c), mIf.tdata, 32'h0107_0007);
        end
        @(posedge aclk);
        #1;
        mIf.tready = 1'b1;
      end
    join
    idle(3);
    checkOutput("t3Count", 32'(outQ.size()), 32'd2);
    checkOutput("t3Out0", qData(0), 32'h0107_0007);
    checkOutput("t3Out1", qData(1), 32'h010F_000F);
    checkOutput("t3Accepted", 32'(inCycQ.size()), 32'd16);

    // log_decim=20 clamps to 16; lane0 at +max, lane1 at -max.
    $display("[TB] test 4: AVG full-scale, clamped L=16");
    clearQueues();
    mode_avg  = 1'b1;
    log_decim = 5'd20;
    for (int i = 0; i < 65536; i++) applyStimulus(32'h8000_7FFF);
    idle(3);
    checkOutput("t4Count", 32'(outQ.size()), 32'd1);
    checkOutput("t4FullScale", qData(0), 32'h8000_7FFF);

    $display("[TB] test 5: config change mid-group");
    clearQueues();
    baseRestart = restartCount;
    mode_avg  = 1'b1;
    log_decim = 5'd2;
    applyStimulus(32'h0032_0064);
    applyStimulus(32'h0032_0064);
    log_decim = 5'd1;
    idle(5);
    checkOutput("t5RestartPulse", 32'(restartCount - baseRestart), 32'd1);
    applyStimulus(32'h000A_0004);
    applyStimulus(32'h0014_0006);
    applyStimulus(32'h0001_FFFF);
    applyStimulus(32'h0000_FFFE);
    idle(2);
    checkOutput("t5CountA", 32'(outQ.size()), 32'd2);
    checkOutput("t5Pair0", qData(0), 32'h000F_0005);
    checkOutput("t5Pair1", qData(1), 32'h0000_FFFE);
    applyStimulus(32'hFFF7_0009);
    log_decim = 5'd2;
    @(posedge aclk);
    #1;
    log_decim = 5'd1;
    idle(4);
    checkOutput("t5GlitchNoRestart", 32'(restartCount - baseRestart), 32'd1);
    applyStimulus(32'hFFF6_000B);
    idle(2);
    checkOutput("t5CountB", 32'(outQ.size()), 32'd3);
    checkOutput("t5Pair2", qData(2), 32'hFFF6_000A);

    $display("[TB] test 6: reset mid-group and mid-stall");
    clearQueues();
    mode_avg  = 1'b0;
    log_decim = 5'd2;
    applyStimulus(32'h0005_0001);
    applyStimulus(32'h0005_0002);
    areset = 1'b1;
    idle(1);
    areset = 1'b0;
    mIf.tready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(32'h0006_0000 + 32'(i));
    @(negedge aclk);
    checkOutput("t6StallValid", 32'(mIf.tvalid), 32'd1);
    checkOutput("t6StallData", mIf.tdata, 32'h0006_0003);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    checkOutput("t6ResetValid", 32'(mIf.tvalid), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    clearQueues();
    mIf.tready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(32'h0007_0010 + 32'(i));
    idle(3);
    checkOutput("t6Count", 32'(outQ.size()), 32'd1);
    checkOutput("t6Out", qData(0), 32'h0007_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
